// File: rtl/pc_sequencer_if.sv
// Interface between the decoder/datapath and the pc_sequencer control FSM.
// The slave modport is the sequencer's view; master is the surrounding datapath's view.
interface pc_sequencer_if #(
  parameter int RETIRE_W = 32
);
  logic                mem_ready;
  logic [2:0]          ins_class;
  logic                branch_taken;
  logic                is_link;
  logic                md_busy;
  logic                exc_req;
  logic                pc_ena;
  logic [1:0]          pc_sel;
  logic                ir_ena;
  logic                mem_req;
  logic                mem_we;
  logic                rf_we;
  logic                md_start;
  logic                epc_ena;
  logic [2:0]          state;
  logic [RETIRE_W-1:0] retired;

  modport slave (
    input  mem_ready, ins_class, branch_taken, is_link, md_busy, exc_req,
    output pc_ena, pc_sel, ir_ena, mem_req, mem_we, rf_we, md_start, epc_ena,
           state, retired
  );

  modport master (
    output mem_ready, ins_class, branch_taken, is_link, md_busy, exc_req,
    input  pc_ena, pc_sel, ir_ena, mem_req, mem_we, rf_we, md_start, epc_ena,
           state, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer: PC load control, datapath strobes, retire count.
// Optional exception path enabled by defining PC_SEQ_EXC_EN.
module pc_sequencer #(
  parameter int RETIRE_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_MDW = 3'd5,
    S_EXC = 3'd6,
    S_ILL = 3'd7
  } state_e;

  localparam logic [2:0] C_ALU    = 3'd0;
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_STORE  = 3'd2;
  localparam logic [2:0] C_BRANCH = 3'd3;
  localparam logic [2:0] C_JUMP   = 3'd4;
  localparam logic [2:0] C_MULDIV = 3'd5;

  localparam logic [1:0] SEL_PC4 = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_JMP = 2'd2;
  localparam logic [1:0] SEL_EXC = 2'd3;

  localparam logic [RETIRE_W-1:0] RET_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  state_e              state_r;
  state_e              next_s;
  logic [RETIRE_W-1:0] retired_r;
  logic                retire_s;
  logic                exc_s;
  logic                pc_ena_s;
  logic [1:0]          pc_sel_s;
  logic                ir_ena_s;
  logic                mem_req_s;
  logic                mem_we_s;
  logic                rf_we_s;
  logic                md_start_s;
  logic                epc_ena_s;

  // Exception request is only honoured when the exception path is built in.
  always_comb begin
`ifdef PC_SEQ_EXC_EN
    exc_s = bus.exc_req;
`else
    exc_s = 1'b0;
`endif
  end

  // Next-state, retire and strobe decode from the current state and decoder inputs.
  always_comb begin
    next_s     = S_IF;
    retire_s   = 1'b0;
    pc_ena_s   = 1'b0;
    pc_sel_s   = SEL_PC4;
    ir_ena_s   = 1'b0;
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    rf_we_s    = 1'b0;
    md_start_s = 1'b0;
    epc_ena_s  = 1'b0;
    case (state_r)
      S_IF: begin
        mem_req_s = 1'b1;
        if (bus.mem_ready) begin
          ir_ena_s = 1'b1;
          pc_ena_s = 1'b1;
          pc_sel_s = SEL_PC4;
          next_s   = S_ID;
        end else begin
          next_s   = S_IF;
        end
      end
      S_ID: begin
        next_s = S_EX;
      end
      S_EX: begin
        if (exc_s) begin
          next_s = S_EXC;
        end else begin
          case (bus.ins_class)
            C_ALU:   next_s = S_WB;
            C_LOAD:  next_s = S_MEM;
            C_STORE: next_s = S_MEM;
            C_BRANCH: begin
              pc_ena_s = bus.branch_taken;
              pc_sel_s = bus.branch_taken ? SEL_BR : SEL_PC4;
              retire_s = 1'b1;
              next_s   = S_IF;
            end
            C_JUMP: begin
              pc_ena_s = 1'b1;
              pc_sel_s = SEL_JMP;
              rf_we_s  = bus.is_link;
              retire_s = 1'b1;
              next_s   = S_IF;
            end
            C_MULDIV: begin
              md_start_s = 1'b1;
              next_s     = S_MDW;
            end
            default: begin
              retire_s = 1'b1;
              next_s   = S_IF;
            end
          endcase
        end
      end
      S_MEM: begin
        mem_req_s = 1'b1;
        mem_we_s  = (bus.ins_class == C_STORE);
        if (!bus.mem_ready) begin
          next_s = S_MEM;
        end else if (bus.ins_class == C_LOAD) begin
          next_s = S_WB;
        end else begin
          retire_s = 1'b1;
          next_s   = S_IF;
        end
      end
      S_WB: begin
        rf_we_s  = 1'b1;
        retire_s = 1'b1;
        next_s   = S_IF;
      end
      S_MDW: begin
        if (bus.md_busy) begin
          next_s = S_MDW;
        end else begin
          retire_s = 1'b1;
          next_s   = S_IF;
        end
      end
`ifdef PC_SEQ_EXC_EN
      S_EXC: begin
        epc_ena_s = 1'b1;
        pc_ena_s  = 1'b1;
        pc_sel_s  = SEL_EXC;
        next_s    = S_IF;
      end
`endif
      default: begin
        next_s = S_IF;
      end
    endcase
  end

  // State and retire counter; reset aborts any in-flight access without retiring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IF;
      retired_r <= '0;
    end else begin
      state_r <= next_s;
      if (retire_s) begin
        retired_r <= retired_r + RET_ONE;
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Strobes are forced low while reset is held, even though IF would request memory.
  assign bus.pc_ena   = pc_ena_s   & ~rst;
  assign bus.pc_sel   = rst ? SEL_PC4 : pc_sel_s;
  assign bus.ir_ena   = ir_ena_s   & ~rst;
  assign bus.mem_req  = mem_req_s  & ~rst;
  assign bus.mem_we   = mem_we_s   & ~rst;
  assign bus.rf_we    = rf_we_s    & ~rst;
  assign bus.md_start = md_start_s & ~rst;
  assign bus.epc_ena  = epc_ena_s  & ~rst;
  assign bus.state    = state_r;
  assign bus.retired  = retired_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: walks each instruction class cycle by cycle.
module tb_pc_sequencer;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  pc_sequencer_if #(.RETIRE_W(32)) bus ();

  pc_sequencer #(.RETIRE_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares every output (packed) and the retire count for the current cycle.
  task automatic exp_cyc(input string tag, input logic [2:0] st, input logic pe,
                         input logic [1:0] ps, input logic ir, input logic mr,
                         input logic mw, input logic rw, input logic ms,
                         input logic ep, input logic [31:0] ret);
    #2;
    chk({tag, ".outs"},
        {20'd0, bus.state, bus.pc_ena, bus.pc_sel, bus.ir_ena, bus.mem_req,
         bus.mem_we, bus.rf_we, bus.md_start, bus.epc_ena},
        {20'd0, st, pe, ps, ir, mr, mw, rw, ms, ep});
    chk({tag, ".retired"}, bus.retired, ret);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst              = 1'b1;
    bus.mem_ready    = 1'b0;
    bus.ins_class    = 3'd0;
    bus.branch_taken = 1'b0;
    bus.is_link      = 1'b0;
    bus.md_busy      = 1'b0;
    bus.exc_req      = 1'b0;
    step();
    step();
    bus.mem_ready = 1'b1;
    exp_cyc("reset", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;

    // ALU
    bus.ins_class = 3'd0;
    exp_cyc("alu_if",  3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0); step();
    exp_cyc("alu_id",  3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0); step();
    exp_cyc("alu_ex",  3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0); step();
    exp_cyc("alu_wb",  3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0); step();

    // LOAD with three wait cycles in MEM
    bus.ins_class = 3'd1;
    exp_cyc("ld_if",   3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1); step();
    exp_cyc("ld_id",   3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1); step();
    bus.mem_ready = 1'b0;
    exp_cyc("ld_ex",   3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1); step();
    for (int i = 0; i < 3; i++) begin
      exp_cyc("ld_mem_wait", 3'd3, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1);
      step();
    end
    bus.mem_ready = 1'b1;
    exp_cyc("ld_mem",  3'd3, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1); step();
    exp_cyc("ld_wb",   3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1); step();

    // BRANCH taken, then not taken
    bus.ins_class = 3'd3;
    bus.branch_taken = 1'b1;
    exp_cyc("bt_if",   3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2); step();
    exp_cyc("bt_id",   3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2); step();
    exp_cyc("bt_ex",   3'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2); step();
    bus.branch_taken = 1'b0;
    exp_cyc("bn_if",   3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3); step();
    exp_cyc("bn_id",   3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3); step();
    exp_cyc("bn_ex",   3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3); step();

    // JUMP and link
    bus.ins_class = 3'd4;
    bus.is_link = 1'b1;
    exp_cyc("jal_if",  3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4); step();
    exp_cyc("jal_id",  3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4); step();
    exp_cyc("jal_ex",  3'd2, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4); step();
    bus.is_link = 1'b0;

    // MULDIV with md_busy high for five MDW cycles
    bus.ins_class = 3'd5;
    exp_cyc("md_if",   3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5); step();
    exp_cyc("md_id",   3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5); step();
    bus.md_busy = 1'b1;
    exp_cyc("md_ex",   3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5); step();
    for (int i = 0; i < 5; i++) begin
      exp_cyc("md_wait", 3'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5);
      step();
    end
    bus.md_busy = 1'b0;
    exp_cyc("md_last", 3'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5); step();

    // STORE with exc_req raised in EX
    bus.ins_class = 3'd2;
    exp_cyc("st_if",   3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6); step();
    exp_cyc("st_id",   3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6); step();
    bus.exc_req = 1'b1;
    exp_cyc("st_ex",   3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6); step();
    bus.exc_req = 1'b0;
`ifdef PC_SEQ_EXC_EN
    exp_cyc("st_exc",  3'd6, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd6); step();
    exp_cyc("st_after", 3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6);
`else
    exp_cyc("st_mem",  3'd3, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd6); step();
    exp_cyc("st_after", 3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7);
`endif

    // LOAD aborted by an asynchronous reset pulse while waiting in MEM
    bus.ins_class = 3'd1;
    step();
    step();
    bus.mem_ready = 1'b0;
    step();
    exp_cyc("ab_mem",  3'd3, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
`ifdef PC_SEQ_EXC_EN
            32'd6);
`else
            32'd7);
`endif
    #1 rst = 1'b1;
    exp_cyc("ab_rst",  3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    step();
    exp_cyc("ab_idle", 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    bus.mem_ready = 1'b1;
    exp_cyc("ab_if",   3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0); step();
    exp_cyc("ab_id",   3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
